uart_rx: RTL and testbench

Serial receiver that deserialises 8N1 UART frames from the board RX pin into parallel bytes. It drives the upstream side of the operand/opcode interface: each correctly received byte appears on `o_dato` with a one-cycle `o_valid` pulse. Three consecutive pulses deliver operand A, operand B and the opcode to the ALU interface. The block contains its own 16x oversampling tick generator, so it needs only the system clock.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/baud_rate_gen.sv | 42 ++++
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART receive path (and a future transmitter):
//   FSM state encoding, default frame/line parameters and the clock divisor
//   used to derive the 16x oversampling tick.
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int NB_DATA_DEF  = 8;
  localparam int SB_TICK_DEF  = 16;
  localparam int BAUD_DEF     = 19200;
  localparam int CLK_FREQ_DEF = 100_000_000;

  // One-hot receiver states
  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    DATA  = 4'b0100,
    STOP  = 4'b1000
  } state_t;

  // Clock cycles per oversampling tick (truncating division)
  function automatic int calc_divisor(input int clk_freq, input int baud);
    return clk_freq / (baud * 16);
  endfunction

endpackage

// File: rtl/baud_rate_gen.sv
// ---------------------------------------------------------------------------
// baud_rate_gen
//   Free-running 16x oversampling tick generator. The counter runs
//   0..DIVISOR-1 and wraps; o_tick is high for the single cycle in which the
//   count equals DIVISOR-1. It is never realigned to the serial frames.
//
//   Ports:
//     i_clock  - system clock (rising edge)
//     i_reset  - asynchronous active-low reset
//     o_tick   - one-cycle pulse at BAUD*16 rate
// ---------------------------------------------------------------------------
module baud_rate_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int BAUD     = BAUD_DEF
) (
  input  logic i_clock,
  input  logic i_reset,
  output logic o_tick
);

  localparam int DIVISOR = calc_divisor(CLK_FREQ, BAUD);
  localparam int CW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(DIVISOR - 1));
  assign o_tick = w_wrap;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver with 16x oversampling. Each good frame updates o_dato
//   with a one-cycle o_valid pulse; a low stop bit gives a one-cycle
//   o_frame_err pulse and leaves o_dato untouched.
//
//   Ports:
//     i_clock      - system clock (rising edge)
//     i_reset      - asynchronous active-low reset
//     i_rx         - asynchronous serial input, idles high
//     o_dato       - last correctly received byte
//     o_valid      - one-cycle pulse with each o_dato update
//     o_frame_err  - one-cycle pulse when the stop bit is sampled low
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int NB_DATA  = NB_DATA_DEF,
  parameter int SB_TICK  = SB_TICK_DEF,
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int BAUD     = BAUD_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_dato,
  output logic               o_valid,
  output logic               o_frame_err
);

  localparam int NW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  logic               r_rx_meta;
  logic               r_rx_sync;
  logic               w_tick;
  state_t             r_state;
  logic [3:0]         r_s_cnt;
  logic [NW-1:0]      r_n;
  logic [NB_DATA-1:0] r_b;
  logic [NB_DATA-1:0] r_dato;
  logic               r_valid;
  logic               r_frame_err;

  baud_rate_gen #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_baud_rate_gen (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .o_tick (w_tick)
  );

  // Two-flop synchroniser; resets to the idle (high) line level
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_s_cnt     <= '0;
      r_n         <= '0;
      r_b         <= '0;
      r_dato      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!r_rx_sync) begin
            r_state <= START;
            r_s_cnt <= '0;
          end
        end
        START: begin
          if (w_tick) begin
            // Eight ticks in: centre of the start bit. A high line here means
            // the falling edge was a glitch, so drop back silently.
            if (r_s_cnt == 4'd7) begin
              if (!r_rx_sync) begin
                r_state <= DATA;
                r_s_cnt <= '0;
                r_n     <= '0;
              end else begin
                r_state <= IDLE;
                r_s_cnt <= '0;
              end
            end else begin
              r_s_cnt <= r_s_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_s_cnt == 4'd15) begin
              // LSB-first line: shift in at the MSB so bit 0 lands last
              r_b     <= {r_rx_sync, r_b[NB_DATA-1:1]};
              r_s_cnt <= '0;
              r_n     <= r_n + 1'b1;
              if (r_n == NW'(NB_DATA - 1)) begin
                r_state <= STOP;
              end
            end else begin
              r_s_cnt <= r_s_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            if (r_s_cnt == 4'(SB_TICK - 1)) begin
              if (r_rx_sync) begin
                r_dato  <= r_b;
                r_valid <= 1'b1;
              end else begin
                r_frame_err <= 1'b1;
              end
              r_state <= IDLE;
              r_s_cnt <= '0;
            end else begin
              r_s_cnt <= r_s_cnt + 4'd1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_s_cnt <= '0;
          r_n     <= '0;
        end
      endcase
    end
  end

  assign o_dato      = r_dato;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//   Directed frames driven onto the serial line; each expected o_valid /
//   o_frame_err event is queued before its frame is sent and a monitor
//   compares every pulse the receiver produces against the queue head.
//   The receiver runs with DIVISOR=4 (one bit = 64 cycles) to keep the run
//   short; the frame format and tick counts are the default ones.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int DIV      = 4;
  localparam int BAUD     = 19200;
  localparam int CLK_FREQ = BAUD * 16 * DIV;
  localparam int BIT      = 16 * DIV;
  // Line-low duration for the break test: three receiver frame periods
  // (152 ticks each) plus a short margin so the line rises after the third
  // stop decision but before the next start-bit centre check.
  localparam int BREAK_LEN = 3 * 152 * DIV + 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dato;
  logic       valid;
  logic       ferr;

  typedef struct packed {
    logic       is_err;
    logic [7:0] dato;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  uart_rx #(
    .NB_DATA (8),
    .SB_TICK (16),
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .i_rx       (rx),
    .o_dato     (dato),
    .o_valid    (valid),
    .o_frame_err(ferr)
  );

  // Monitor: every output pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && (valid || ferr)) begin
      exp_t e;
      tests++;
      if (valid && ferr) begin
        fails++;
        $display("FAIL both_pulses: valid=%0b frame_err=%0b, required never both high", valid, ferr);
      end
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b dato=%02h, required no pulse",
                 valid, ferr, dato);
      end else begin
        e = sb_q.pop_front();
        tests++;
        if (ferr !== e.is_err || valid !== !e.is_err) begin
          fails++;
          $display("FAIL pulse_kind: valid=%0b frame_err=%0b, required frame_err=%0b",
                   valid, ferr, e.is_err);
        end
        tests++;
        if (dato !== e.dato) begin
          fails++;
          $display("FAIL dato: got %02h, required %02h", dato, e.dato);
        end else begin
          $display("[TB] %s dato=%02h ok", e.is_err ? "frame_err" : "valid   ", dato);
        end
      end
    end
  end

  // Drive the line; every call starts and ends 1 time unit after a rising edge
  task automatic drive_line(input logic v, input int cycles);
    rx = v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    drive_line(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_line(d[i], BIT);
    drive_line(stop_bit, BIT);
  endtask

  task automatic expect_ev(input logic is_err, input logic [7:0] d);
    exp_t e;
    e.is_err = is_err;
    e.dato   = d;
    sb_q.push_back(e);
  endtask

  task automatic check_drained(input string name);
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL %s_missing: %0d expected pulses not seen, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check_outputs_zero(input string name);
    tests++;
    if (dato !== 8'h00 || valid !== 1'b0 || ferr !== 1'b0) begin
      fails++;
      $display("FAIL %s: dato=%02h valid=%0b frame_err=%0b, required 00/0/0",
               name, dato, valid, ferr);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_outputs_zero("reset_state");
    rst_n = 1'b1;
    drive_line(1'b1, 2 * BIT);

    // Single good frame
    expect_ev(1'b0, 8'h55);
    send_frame(8'h55, 1'b1);
    drive_line(1'b1, BIT);
    check_drained("frame_55");

    // Back-to-back frames, no idle gap
    expect_ev(1'b0, 8'h03);
    expect_ev(1'b0, 8'h05);
    expect_ev(1'b0, 8'h20);
    send_frame(8'h03, 1'b1);
    send_frame(8'h05, 1'b1);
    send_frame(8'h20, 1'b1);
    drive_line(1'b1, BIT);
    check_drained("back_to_back");

    // Short low glitch is rejected; next frame still received
    drive_line(1'b0, 16);
    drive_line(1'b1, 2 * BIT);
    check_drained("glitch");
    expect_ev(1'b0, 8'h81);
    send_frame(8'h81, 1'b1);
    drive_line(1'b1, BIT);
    check_drained("after_glitch");

    // Bad stop bit after a good 0x55: error pulse, o_dato keeps 0x55
    expect_ev(1'b0, 8'h55);
    send_frame(8'h55, 1'b1);
    expect_ev(1'b1, 8'h55);
    send_frame(8'hA5, 1'b0);
    drive_line(1'b1, 2 * BIT);
    check_drained("frame_err");

    // Reset in the middle of data bit 4 of 0xFF
    drive_line(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive_line(1'b1, BIT);
    drive_line(1'b1, BIT / 2);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_frame_reset");
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_line(1'b1, 4 * BIT);
    check_drained("reset_abort");
    expect_ev(1'b0, 8'h3C);
    send_frame(8'h3C, 1'b1);
    drive_line(1'b1, BIT);
    check_drained("after_reset");

    // Break: line low for three frame times -> three frame errors
    expect_ev(1'b1, 8'h3C);
    expect_ev(1'b1, 8'h3C);
    expect_ev(1'b1, 8'h3C);
    drive_line(1'b0, BREAK_LEN);
    drive_line(1'b1, 2 * BIT);
    check_drained("break");
    expect_ev(1'b0, 8'h7E);
    send_frame(8'h7E, 1'b1);
    drive_line(1'b1, 2 * BIT);
    check_drained("after_break");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
